// File: rtl/iob_cache_axi_pkg.sv
// Shared AXI response codes and FSM state encodings for the cache back-end memory slave.
package iob_cache_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

// File: rtl/iob_cache_axi_mem_ram.sv
// Word-addressed RAM: one byte-enabled write port, one registered read port (1-cycle latency).
module iob_cache_axi_mem_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic [DATA_W/8-1:0] we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                re_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < DATA_W/8; b++) begin
      if (we_i[b]) mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
  end

  // Output register only updates on a read request, so it holds during R-channel stalls
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)  rdata_o <= '0;
    else if (re_i)  rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/iob_cache_axi_mem_slave.sv
// AXI4 INCR-burst memory slave backing the cache; independent read and write FSMs over a sync RAM.
module iob_cache_axi_mem_slave
  import iob_cache_axi_pkg::*;
#(
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 8,
  parameter int MEM_ADDR_W = 10
) (
  input  logic                    clk_i,
  input  logic                    arst_n_i,
  input  logic [AXI_ID_W-1:0]     axi_awid_i,
  input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
  input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
  input  logic                    axi_wlast_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  output logic [AXI_ID_W-1:0]     axi_bid_o,
  output logic [1:0]              axi_bresp_o,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  input  logic [AXI_ID_W-1:0]     axi_arid_i,
  input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  output logic [AXI_ID_W-1:0]     axi_rid_o,
  output logic [AXI_DATA_W-1:0]   axi_rdata_o,
  output logic [1:0]              axi_rresp_o,
  output logic                    axi_rlast_o,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i
);

  localparam int BYTE_W = $clog2(AXI_DATA_W/8);

  w_state_t                w_state, w_state_nxt;
  logic [MEM_ADDR_W-1:0]   w_idx;
  logic [AXI_LEN_W-1:0]    w_len, w_cnt;
  logic                    w_err, aw_rdy, aw_hs, w_hs, w_last_beat, w_beat_err;
  logic [AXI_ID_W-1:0]     b_id;
  logic [1:0]              b_resp;

  r_state_t                r_state, r_state_nxt;
  logic [MEM_ADDR_W-1:0]   r_idx, ar_idx, ram_raddr;
  logic [AXI_LEN_W-1:0]    r_len, r_cnt;
  logic                    ar_rdy, ar_hs, r_hs, r_last_beat, ram_re;
  logic [AXI_ID_W-1:0]     r_id;

  assign aw_hs       = aw_rdy && axi_awvalid_i;
  assign w_hs        = (w_state == W_DATA) && axi_wvalid_i;
  assign w_last_beat = (w_cnt == w_len);
  // A burst errors if wlast disagrees with the beat count on any beat, early or missing
  assign w_beat_err  = w_err || (axi_wlast_i != w_last_beat);

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_nxt = W_RESP;
      W_RESP:  if (axi_bready_i) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      w_state <= W_IDLE;
      aw_rdy  <= 1'b0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      b_id    <= '0;
      b_resp  <= AXI_RESP_OKAY;
    end else begin
      w_state <= w_state_nxt;
      aw_rdy  <= (w_state_nxt == W_IDLE);
      if (aw_hs) begin
        b_id  <= axi_awid_i;
        w_idx <= axi_awaddr_i[BYTE_W+MEM_ADDR_W-1:BYTE_W];
        w_len <= axi_awlen_i;
        w_cnt <= '0;
        w_err <= 1'b0;
      end
      if (w_hs) begin
        w_idx <= w_idx + MEM_ADDR_W'(1);
        w_cnt <= w_cnt + AXI_LEN_W'(1);
        w_err <= w_beat_err;
        if (w_last_beat) b_resp <= w_beat_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
    end
  end

  assign axi_awready_o = aw_rdy;
  assign axi_wready_o  = (w_state == W_DATA);
  assign axi_bvalid_o  = (w_state == W_RESP);
  assign axi_bid_o     = b_id;
  assign axi_bresp_o   = b_resp;

  assign ar_idx      = axi_araddr_i[BYTE_W+MEM_ADDR_W-1:BYTE_W];
  assign ar_hs       = ar_rdy && axi_arvalid_i;
  assign r_hs        = (r_state == R_DATA) && axi_rready_i;
  assign r_last_beat = (r_cnt == r_len);
  // Fetch the first word on AR, then prefetch the next one whenever a non-final beat is taken
  assign ram_re      = ar_hs || (r_hs && !r_last_beat);
  assign ram_raddr   = ar_hs ? ar_idx : r_idx;

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && r_last_beat) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= R_IDLE;
      ar_rdy  <= 1'b0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_id    <= '0;
    end else begin
      r_state <= r_state_nxt;
      ar_rdy  <= (r_state_nxt == R_IDLE);
      if (ar_hs) begin
        r_id  <= axi_arid_i;
        r_idx <= ar_idx + MEM_ADDR_W'(1);
        r_len <= axi_arlen_i;
        r_cnt <= '0;
      end else if (r_hs && !r_last_beat) begin
        r_idx <= r_idx + MEM_ADDR_W'(1);
        r_cnt <= r_cnt + AXI_LEN_W'(1);
      end
    end
  end

  assign axi_arready_o = ar_rdy;
  assign axi_rvalid_o  = (r_state == R_DATA);
  assign axi_rlast_o   = (r_state == R_DATA) && r_last_beat;
  assign axi_rid_o     = r_id;
  assign axi_rresp_o   = AXI_RESP_OKAY;

  iob_cache_axi_mem_ram #(
    .DATA_W (AXI_DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .we_i     (w_hs ? axi_wstrb_i : '0),
    .waddr_i  (w_idx),
    .wdata_i  (axi_wdata_i),
    .re_i     (ram_re),
    .raddr_i  (ram_raddr),
    .rdata_o  (axi_rdata_o)
  );

endmodule
